// File: rtl/ws_matmul_pkg.sv
// Shared definitions for the weight-stationary matmul engine: FSM state codes and
// the saturating adder used when the engine is built with WS_MATMUL_SAT_EN.
package ws_matmul_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_LOAD    = 2'd1;
  localparam state_t ST_COMPUTE = 2'd2;
  localparam state_t ST_DRAIN   = 2'd3;

  // Returns {clip, sum} with the sum clamped to a signed w-bit range (w <= 63).
  function automatic logic [64:0] sat_add(input logic signed [63:0] a,
                                          input logic signed [63:0] b,
                                          input int w);
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    s  = 65'(a) + 65'(b);
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -hi - 65'sd1;
    if (s > hi) return {1'b1, hi[63:0]};
    if (s < lo) return {1'b1, lo[63:0]};
    return {1'b0, s[63:0]};
  endfunction

endpackage

// File: rtl/ws_matmul_engine_pe.sv
// Single processing element: stationary weight, activation passed right, partial sum
// passed down. Saturating add when WS_MATMUL_SAT_EN is defined, wrapping otherwise.
module ws_pe
  import ws_matmul_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     wt_load,
  input  logic signed [DATA_W-1:0] wt_in,
  output logic signed [DATA_W-1:0] wt_out,
  input  logic signed [DATA_W-1:0] a_in,
  output logic signed [DATA_W-1:0] a_out,
  input  logic signed [ACC_W-1:0]  psum_in,
  output logic signed [ACC_W-1:0]  psum_out,
  output logic                     clip
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    sum;

  assign prod     = a_in * wt_out;
  assign prod_ext = ACC_W'(prod);

`ifdef WS_MATMUL_SAT_EN
  logic [64:0] sat_res;
  assign sat_res = sat_add(64'(psum_in), 64'(prod_ext), ACC_W);
  assign sum     = sat_res[ACC_W-1:0];
  assign clip    = sat_res[64];
`else
  assign sum  = psum_in + prod_ext;
  assign clip = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wt_out   <= '0;
      a_out    <= '0;
      psum_out <= '0;
    end else begin
      if (wt_load) wt_out <= wt_in;
      if (en) begin
        a_out    <= a_in;
        psum_out <= sum;
      end
    end
  end

endmodule

// File: rtl/ws_matmul_engine.sv
// Weight-stationary ROWS x COLS systolic matmul with input skew, output de-skew and
// full backpressure. Optional saturation: define WS_MATMUL_SAT_EN.
module ws_matmul_engine
  import ws_matmul_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wt_valid,
  output logic                   wt_ready,
  input  logic [COLS*DATA_W-1:0] wt_row,
  input  logic                   act_valid,
  output logic                   act_ready,
  input  logic [ROWS*DATA_W-1:0] act_vec,
  input  logic                   act_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COLS*ACC_W-1:0]  out_vec,
  output logic                   out_last,
  output logic                   busy,
  output logic                   ovf
);

  localparam int DEPTH = ROWS + COLS;
  localparam int CNT_W = $clog2(ROWS + 1);

  state_t             state;
  logic [CNT_W-1:0]   beat_cnt;
  logic               en, wt_fire, act_fire;
  logic [DEPTH-1:0]   vld_pipe, last_pipe;
  logic [ROWS*COLS-1:0] clip_bits;
  logic [COLS*ACC_W-1:0] col_flat;

  logic signed [DATA_W-1:0] a_left [ROWS];
  logic signed [DATA_W-1:0] a_bus  [ROWS][COLS];
  logic signed [DATA_W-1:0] w_bus  [ROWS][COLS];
  logic signed [ACC_W-1:0]  p_bus  [ROWS][COLS];

  assign en        = ~(out_valid & ~out_ready);
  assign wt_ready  = reset & ((state == ST_IDLE) | (state == ST_LOAD));
  assign act_ready = reset & (state == ST_COMPUTE) & en;
  assign wt_fire   = wt_valid & wt_ready;
  assign act_fire  = act_valid & act_ready;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (wt_fire) begin
          state    <= (ROWS == 1) ? ST_COMPUTE : ST_LOAD;
          beat_cnt <= CNT_W'(1);
        end
        ST_LOAD: if (wt_fire) begin
          if (beat_cnt == CNT_W'(ROWS - 1)) state <= ST_COMPUTE;
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
        ST_COMPUTE: if (act_fire && act_last) state <= ST_DRAIN;
        default: if (vld_pipe == '0 && (!out_valid || out_ready)) state <= ST_IDLE;
      endcase
    end
  end

  // Sticky clip flag; a fresh weight load starts a new observation window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         ovf <= 1'b0;
    else if (state == ST_IDLE && wt_fire) ovf <= 1'b0;
    else if (en && |clip_bits)          ovf <= 1'b1;
  end

  // Input skew: row r sees its element r cycles later; bubbles inject zeros.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic signed [DATA_W-1:0] sk [r+1];
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k <= r; k++) sk[k] <= '0;
      end else if (en) begin
        sk[0] <= act_fire ? act_vec[r*DATA_W +: DATA_W] : '0;
        for (int k = 1; k <= r; k++) sk[k] <= sk[k-1];
      end
    end
    assign a_left[r] = sk[r];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic signed [DATA_W-1:0] a_in, w_in;
      logic signed [ACC_W-1:0]  p_in;
      if (c == 0) begin : g_a0
        assign a_in = a_left[r];
      end else begin : g_an
        assign a_in = a_bus[r][c-1];
      end
      if (r == 0) begin : g_top
        assign w_in = wt_row[c*DATA_W +: DATA_W];
        assign p_in = '0;
      end else begin : g_inner
        assign w_in = w_bus[r-1][c];
        assign p_in = p_bus[r-1][c];
      end
      ws_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .wt_load (wt_fire),
        .wt_in   (w_in),
        .wt_out  (w_bus[r][c]),
        .a_in    (a_in),
        .a_out   (a_bus[r][c]),
        .psum_in (p_in),
        .psum_out(p_bus[r][c]),
        .clip    (clip_bits[r*COLS+c])
      );
    end
  end

  // Output de-skew: column c waits COLS-1-c cycles so all columns line up.
  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    localparam int N = COLS - 1 - c;
    if (N == 0) begin : g_direct
      assign col_flat[c*ACC_W +: ACC_W] = p_bus[ROWS-1][c];
    end else begin : g_delay
      logic signed [ACC_W-1:0] ds [N];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < N; k++) ds[k] <= '0;
        end else if (en) begin
          ds[0] <= p_bus[ROWS-1][c];
          for (int k = 1; k < N; k++) ds[k] <= ds[k-1];
        end
      end
      assign col_flat[c*ACC_W +: ACC_W] = ds[N-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_vec   <= '0;
    end else if (en) begin
      vld_pipe  <= {vld_pipe[DEPTH-2:0], act_fire};
      last_pipe <= {last_pipe[DEPTH-2:0], act_fire & act_last};
      out_valid <= vld_pipe[DEPTH-1];
      out_last  <= last_pipe[DEPTH-1];
      out_vec   <= col_flat;
    end
  end

endmodule

// File: tb/tb_ws_matmul_engine.sv
// Scoreboard bench for ws_matmul_engine: a plain-arithmetic matrix model predicts each
// result; a monitor pops and compares whenever a result is handed downstream.
module tb_ws_matmul_engine;

  localparam int ROWS = 4, COLS = 4, DATA_W = 8, ACC_W = 16, LAT = ROWS + COLS;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   wt_valid = 1'b0;
  logic                   wt_ready;
  logic [COLS*DATA_W-1:0] wt_row = '0;
  logic                   act_valid = 1'b0;
  logic                   act_ready;
  logic [ROWS*DATA_W-1:0] act_vec = '0;
  logic                   act_last = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [COLS*ACC_W-1:0]  out_vec;
  logic                   out_last;
  logic                   busy;
  logic                   ovf;

  ws_matmul_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_row(wt_row),
    .act_valid(act_valid), .act_ready(act_ready), .act_vec(act_vec), .act_last(act_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_last(out_last),
    .busy(busy), .ovf(ovf)
  );

  typedef struct {
    logic [COLS*ACC_W-1:0] vec;
    bit                    last;
    int                    acc_cyc;
    bit                    chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0, n_fail = 0, cyc = 0;
  int   wmat [ROWS][COLS];
  bit   bp_rand = 0, force_low = 0, chk_lat_en = 1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = bp_rand ? ($urandom_range(0, 2) != 0) : !force_low;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: handshake timeout at cycle %0d", name, cyc);
  endtask

  // Column c result is the dot product of the activation vector with weight column c.
  function automatic logic [COLS*ACC_W-1:0] model(input int a[ROWS]);
    logic [COLS*ACC_W-1:0] v;
    longint acc;
    longint hi, lo;
    hi = (longint'(1) <<< (ACC_W - 1)) - 1;
    lo = -hi - 1;
    v = '0;
    for (int c = 0; c < COLS; c++) begin
      acc = 0;
      for (int r = 0; r < ROWS; r++) begin
        acc += longint'(a[r]) * longint'(wmat[r][c]);
`ifdef WS_MATMUL_SAT_EN
        if (acc > hi) acc = hi;
        if (acc < lo) acc = lo;
`endif
      end
      v[c*ACC_W +: ACC_W] = acc[ACC_W-1:0];
    end
    return v;
  endfunction

  task automatic load_w();
    bit ok;
    int t;
    for (int b = 0; b < ROWS; b++) begin
      for (int c = 0; c < COLS; c++) wt_row[c*DATA_W +: DATA_W] = DATA_W'(wmat[ROWS-1-b][c]);
      wt_valid = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        ok = wt_ready;
        @(posedge clk);
        t++;
      end while (!ok && t < 200);
      #1;
      if (!ok) timeout("wt_handshake");
    end
    wt_valid = 1'b0;
  endtask

  task automatic send_act(input int a[ROWS], input bit last);
    bit ok;
    int t;
    exp_t e;
    for (int r = 0; r < ROWS; r++) act_vec[r*DATA_W +: DATA_W] = DATA_W'(a[r]);
    act_valid = 1'b1;
    act_last  = last;
    t = 0;
    do begin
      @(negedge clk);
      ok = act_ready;
      @(posedge clk);
      t++;
    end while (!ok && t < 200);
    #1;
    act_valid = 1'b0;
    act_last  = 1'b0;
    if (!ok) timeout("act_handshake");
    else begin
      e.vec = model(a); e.last = last; e.acc_cyc = cyc; e.chk_lat = chk_lat_en;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((busy || sb.size() != 0) && t < 400);
    if (busy || sb.size() != 0) timeout("drain");
    @(posedge clk);
    #1;
  endtask

  task automatic rand_w();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) wmat[r][c] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic rand_a(output int a[ROWS]);
    for (int r = 0; r < ROWS; r++) a[r] = int'($urandom_range(0, 255)) - 128;
  endtask

  // Monitor: latency on first presentation, value/last on acceptance, hold while stalled.
  initial begin
    bit presenting = 0;
    logic [COLS*ACC_W-1:0] held_vec = '0;
    bit held_last = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) presenting = 0;
      else begin
        if (out_valid && !out_ready) check("act_ready_during_stall", 64'(act_ready), 64'(0));
        if (presenting && out_valid) begin
          check("hold_vec", 64'(out_vec), 64'(held_vec));
          check("hold_last", 64'(out_last), 64'(held_last));
        end
        if (out_valid) begin
          if (!presenting) begin
            if (sb.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_out: got %0h with empty scoreboard", out_vec);
            end else if (sb[0].chk_lat) check("latency", 64'(cyc - sb[0].acc_cyc), 64'(LAT));
          end
          if (out_ready) begin
            if (sb.size() != 0) begin
              e = sb.pop_front();
              check("out_vec", 64'(out_vec), 64'(e.vec));
              check("out_last", 64'(out_last), 64'(e.last));
            end
            presenting = 0;
          end else begin
            presenting = 1;
            held_vec   = out_vec;
            held_last  = out_last;
          end
        end
      end
    end
  end

  initial begin
    int a[ROWS];
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_wt_ready", 64'(wt_ready), 64'(0));
    check("rst_act_ready", 64'(act_ready), 64'(0));
    check("rst_ovf", 64'(ovf), 64'(0));
    check("rst_out_vec", 64'(out_vec), 64'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // Identity weights
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) wmat[r][c] = (r == c) ? 1 : 0;
    load_w();
    a = '{1, 2, 3, 4};
    send_act(a, 1'b1);
    check("identity_expect", 64'(sb[0].vec), 64'h0004_0003_0002_0001);
    wait_idle();

    // Row-constant weights, four back-to-back all-ones vectors
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) wmat[r][c] = r + 1;
    load_w();
    a = '{1, 1, 1, 1};
    for (int k = 0; k < 4; k++) send_act(a, k == 3);
    wait_idle();

    // Backpressure window in the middle of a stream
    chk_lat_en = 0;
    load_w();
    fork
      begin
        repeat (10) @(posedge clk);
        force_low = 1;
        repeat (3) @(posedge clk);
        force_low = 0;
      end
    join_none
    for (int k = 0; k < 8; k++) begin
      rand_a(a);
      send_act(a, k == 7);
    end
    wait_idle();
    chk_lat_en = 1;

    // Extreme operands: sum exceeds the accumulator range
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) wmat[r][c] = -128;
    load_w();
    a = '{-128, -128, -128, -128};
    send_act(a, 1'b1);
    wait_idle();
`ifdef WS_MATMUL_SAT_EN
    check("ovf_after_clip", 64'(ovf), 64'(1));
`else
    check("ovf_wrap_mode", 64'(ovf), 64'(0));
`endif

    // Weight traffic during COMPUTE must be refused
    rand_w();
    load_w();
    wt_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < COLS; c++) wt_row[c*DATA_W +: DATA_W] = DATA_W'($urandom);
      @(negedge clk);
      check("wt_ready_in_compute", 64'(wt_ready), 64'(0));
      @(posedge clk);
      #1;
      rand_a(a);
      send_act(a, k == 3);
    end
    wt_valid = 1'b0;
    wait_idle();

    // Reset in the middle of COMPUTE, then a full reload
    rand_w();
    load_w();
    for (int k = 0; k < 3; k++) begin
      rand_a(a);
      send_act(a, 1'b0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_wt_ready", 64'(wt_ready), 64'(0));
    check("midrst_act_ready", 64'(act_ready), 64'(0));
    @(posedge clk);
    #1 reset = 1'b1;
    rand_w();
    load_w();
    for (int k = 0; k < 5; k++) begin
      rand_a(a);
      send_act(a, k == 4);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_idle();

    // Random batches with random bubbles and random backpressure
    bp_rand = 1;
    chk_lat_en = 0;
    for (int b = 0; b < 3; b++) begin
      rand_w();
      load_w();
      for (int k = 0; k < 12; k++) begin
        rand_a(a);
        send_act(a, k == 11);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      wait_idle();
    end
    bp_rand = 0;
    repeat (4) @(posedge clk);
    #1;

    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
